stc_pulse_encoder: RTL and testbench
====================================

// Module: stc_pulse_encoder
// PURPOSE
//  Binary-to-temporal encoder: the transmit end of the pulse-width space-time code consumed by the
//  min/max operator blocks. Accepts a binary spike time per gamma cycle and emits a PULSE_WIDTH-wide
//  pulse on y starting at that time offset within the gamma cycle. Also generates the gamma-cycle
//  boundary strobe, which downstream operators use as their per-cycle latch reset.
// PARAMETERS
//  GAMMA_CYCLE_WIDTH  16   width of the gamma counter and of spike-time values
//  GAMMA_LEN          256  aclk cycles per gamma cycle; 2 <= GAMMA_LEN <= 2**GAMMA_CYCLE_WIDTH
//  PULSE_WIDTH        8    y pulse length in aclk cycles; 1 <= PULSE_WIDTH <= GAMMA_LEN
// PORTS
//  aclk         in   1   clock
//  grst         in   1   synchronous active-high reset
//  t_in         in   GAMMA_CYCLE_WIDTH  spike time to encode (aclk cycles after gamma start)
//  t_inf        in   1   qualifies t_in: 1 = "no spike" (infinity); t_in is ignored
//  t_valid      in   1   t_in/t_inf offered
//  t_ready      out  1   encoder can accept; transfer when t_valid & t_ready at the clock edge
//  y            out  1   temporal-coded pulse output
//  gamma_start  out  1   high for the single cycle in which gamma_cnt == 0
//  gamma_cnt    out  GAMMA_CYCLE_WIDTH  current position in the gamma cycle, 0..GAMMA_LEN-1
//  ovf          out  1   1-cycle strobe: committed value was out of range and is sent as infinity
// BEHAVIOUR
//  Reset (grst high at edge): gamma_cnt=0, pending slot empty, active=inf, y=0, ovf=0, t_ready=1.
//   gamma_start=1 in the first cycle after grst deasserts. Reset mid-pulse: y is 0 from the next cycle.
//   The pending value and any in-flight pulse are discarded.
//  Gamma counter: free-running, 0..GAMMA_LEN-1, wraps to 0. The "wrap edge" is the edge leaving
//   GAMMA_LEN-1.
//  Buffering: one pending slot plus one active register.
//   - t_ready = !pending_full, taken combinationally from registers only; no dependence on t_valid.
//   - A handshake while the slot is empty fills it: captured t_in and t_inf.
//   - At the wrap edge, active <= pending and the slot is emptied. t_ready is 1 in cycle cnt==0.
//   - Wrap edge with the slot empty and a handshake on that edge: the offered value bypasses the slot.
//     It goes directly to active and the slot stays empty.
//   - Wrap edge with the slot empty and no handshake: active <= inf.
//  Range check at commit: a finite t > GAMMA_LEN-PULSE_WIDTH is committed as inf.
//   ovf=1 in cycle cnt==0 of that gamma cycle; otherwise ovf=0.
//  Pulse state machine, per gamma cycle (state re-entered at every wrap edge):
//   IDLE  - active=inf. y=0 for the whole cycle.
//   WAIT  - cnt < t. y=0.
//   FIRE  - y=1 exactly in the cycles where cnt in [t, t+PULSE_WIDTH-1]. A PULSE_WIDTH down-counter
//           runs in this state.
//   DONE  - y=0 until the wrap edge.
//   t=0 enters FIRE directly at the wrap edge, so y=1 at cnt==0.
//   The range check guarantees that no pulse crosses a gamma boundary.
//   y is driven from a flop (glitch-free), aligned to gamma_cnt as stated above.
//  Exactly one pulse, or none, per gamma cycle. y is never high at cnt==0 unless t==0.
// TESTING (GAMMA_LEN=16, PULSE_WIDTH=4, GAMMA_CYCLE_WIDTH=8 unless noted)
//  1. Reset, then send t=3 during the first gamma cycle -> next gamma cycle: y=1 at cnt 3..6 only.
//     gamma_start=1 at cnt 0 each cycle.
//  2. No transfers at all -> y=0 and ovf=0 forever. gamma_start pulses every 16 cycles.
//  3. t=12 -> y=1 at cnt 12..15. t=13 -> y=0 for that whole cycle and ovf=1 at cnt 0.
//     t_inf=1 -> no pulse and ovf=0.
//  4. Back-to-back: t=2 accepted, t=5 offered immediately -> t_ready=0 until the wrap edge.
//     t=5 is accepted in the following cycle. Pulses at cnt 2..5, then at cnt 5..8 one gamma later.
//  5. Handshake with t=0 on the wrap edge, slot empty -> bypass: y=1 at cnt 0..3 of the gamma cycle
//     just starting. t_ready stays 1.
//  6. Pulse active with t=3: assert grst at cnt 4 for 2 cycles -> y=0 from the next cycle.
//     gamma_cnt=0 and gamma_start=1 on the first cycle after release. No pulse until new data.

Source files
------------

// File: rtl/stc_pulse_encoder.sv
// Pulse-width space-time code transmitter: turns a binary spike time into a PULSE_WIDTH-wide pulse
// at that offset within the gamma cycle, and generates the gamma-cycle boundary strobe.
module stc_pulse_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int GAMMA_LEN         = 256,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                         aclk,
  input  logic                         grst,
  input  logic [GAMMA_CYCLE_WIDTH-1:0] t_in,
  input  logic                         t_inf,
  input  logic                         t_valid,
  output logic                         t_ready,
  output logic                         y,
  output logic                         gamma_start,
  output logic [GAMMA_CYCLE_WIDTH-1:0] gamma_cnt,
  output logic                         ovf
);

  localparam int W    = GAMMA_CYCLE_WIDTH;
  localparam int PW_W = $clog2(PULSE_WIDTH + 1);

  localparam logic [W-1:0]    CNT_MAX = W'(GAMMA_LEN - 1);
  localparam logic [W-1:0]    CNT_ONE = W'(1);
  localparam logic [W:0]      T_LIMIT = (W + 1)'(GAMMA_LEN - PULSE_WIDTH);
  localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_WIDTH - 1);
  localparam logic [PW_W-1:0] PW_ONE  = PW_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic            pend_full;
  logic [W-1:0]    pend_t;
  logic            pend_inf;
  logic [1:0]      state;
  logic [W-1:0]    act_t;
  logic [PW_W-1:0] pw_cnt;

  logic            wrap;
  logic            hs;
  logic [W-1:0]    commit_t;
  logic            commit_inf_raw;
  logic            commit_ovf;
  logic            commit_inf;

  assign t_ready     = !pend_full;
  assign gamma_start = (gamma_cnt == '0);
  assign wrap        = (gamma_cnt == CNT_MAX);
  assign hs          = t_valid && t_ready;

  // Value committed at the wrap edge: pending slot first, else a same-edge handshake bypasses
  // the slot, else infinity. Out-of-range finite times are demoted to infinity.
  assign commit_t       = pend_full ? pend_t : t_in;
  assign commit_inf_raw = pend_full ? pend_inf : (hs ? t_inf : 1'b1);
  assign commit_ovf     = !commit_inf_raw && ({1'b0, commit_t} > T_LIMIT);
  assign commit_inf     = commit_inf_raw || commit_ovf;

  always_ff @(posedge aclk) begin
    if (grst) begin
      gamma_cnt <= '0;
      ovf       <= 1'b0;
      pend_full <= 1'b0;
      pend_t    <= '0;
      pend_inf  <= 1'b1;
      state     <= S_IDLE;
      act_t     <= '0;
      pw_cnt    <= '0;
      y         <= 1'b0;
    end else begin
      gamma_cnt <= wrap ? '0 : gamma_cnt + CNT_ONE;
      ovf       <= wrap && commit_ovf;

      if (wrap) begin
        pend_full <= 1'b0;
      end else if (hs) begin
        pend_full <= 1'b1;
        pend_t    <= t_in;
        pend_inf  <= t_inf;
      end

      // y is registered so it rises exactly when gamma_cnt reaches the spike time.
      if (wrap) begin
        act_t <= commit_t;
        if (commit_inf) begin
          state <= S_IDLE;
          y     <= 1'b0;
        end else if (commit_t == '0) begin
          state  <= S_FIRE;
          y      <= 1'b1;
          pw_cnt <= PW_LAST;
        end else begin
          state <= S_WAIT;
          y     <= 1'b0;
        end
      end else begin
        case (state)
          S_WAIT: begin
            if (gamma_cnt == act_t - CNT_ONE) begin
              state  <= S_FIRE;
              y      <= 1'b1;
              pw_cnt <= PW_LAST;
            end
          end
          S_FIRE: begin
            if (pw_cnt == '0) begin
              state <= S_DONE;
              y     <= 1'b0;
            end else begin
              pw_cnt <= pw_cnt - PW_ONE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stc_pulse_encoder.sv
// Directed bench for stc_pulse_encoder with GAMMA_LEN=16, PULSE_WIDTH=4, 8-bit times;
// a software gamma counter tracks the expected position in every cycle.
module tb_stc_pulse_encoder;

  localparam int GW  = 8;
  localparam int GL  = 16;
  localparam int PWD = 4;

  logic          aclk = 1'b0;
  logic          grst;
  logic [GW-1:0] t_in;
  logic          t_inf;
  logic          t_valid;
  logic          t_ready;
  logic          y;
  logic          gamma_start;
  logic [GW-1:0] gamma_cnt;
  logic          ovf;

  int nChecks = 0;
  int nFails  = 0;
  int tcnt    = 0;

  stc_pulse_encoder #(
    .GAMMA_CYCLE_WIDTH(GW),
    .GAMMA_LEN(GL),
    .PULSE_WIDTH(PWD)
  ) dut (
    .aclk(aclk),
    .grst(grst),
    .t_in(t_in),
    .t_inf(t_inf),
    .t_valid(t_valid),
    .t_ready(t_ready),
    .y(y),
    .gamma_start(gamma_start),
    .gamma_cnt(gamma_cnt),
    .ovf(ovf)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cnt=%0d got=timeout expected=finish", tcnt);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s cnt=%0d got=%0d expected=%0d", tag, tcnt, actual, expected);
    end
  endtask

  // One clock; the model counter follows reset and wrap.
  task automatic tick();
    @(posedge aclk);
    #1;
    if (grst) tcnt = 0;
    else tcnt = (tcnt + 1) % GL;
  endtask

  task automatic advanceTo(input int k);
    while (tcnt != k) tick();
  endtask

  // Checks every cycle from the current position to the end of the gamma cycle.
  task automatic runGamma(input int lo, input int hi, input bit expOvf);
    do begin
      checkOutput("gamma_cnt", int'(gamma_cnt), tcnt);
      checkOutput("gamma_start", int'(gamma_start), int'(tcnt == 0));
      checkOutput("y", int'(y), int'(tcnt >= lo && tcnt <= hi));
      checkOutput("ovf", int'(ovf), int'(expOvf && tcnt == 0));
      tick();
    end while (tcnt != 0);
  endtask

  task automatic applyStimulus(input int t, input bit inf);
    t_valid = 1'b1;
    t_in    = GW'(t);
    t_inf   = inf;
    for (int k = 0; k < 40 && !t_ready; k++) tick();
    checkOutput("hs_ready", int'(t_ready), 1);
    tick();
    t_valid = 1'b0;
  endtask

  task automatic doReset(input int n);
    grst = 1'b1;
    repeat (n) tick();
    grst = 1'b0;
  endtask

  initial begin
    grst    = 1'b0;
    t_in    = '0;
    t_inf   = 1'b0;
    t_valid = 1'b0;
    doReset(2);

    $display("[TB] reset and single pulse at t=3");
    checkOutput("rst_cnt", int'(gamma_cnt), 0);
    checkOutput("rst_start", int'(gamma_start), 1);
    checkOutput("rst_y", int'(y), 0);
    checkOutput("rst_ovf", int'(ovf), 0);
    checkOutput("rst_ready", int'(t_ready), 1);
    applyStimulus(3, 1'b0);
    checkOutput("slot_full", int'(t_ready), 0);
    runGamma(99, -1, 1'b0);
    runGamma(3, 6, 1'b0);

    $display("[TB] idle gamma cycles");
    runGamma(99, -1, 1'b0);
    runGamma(99, -1, 1'b0);

    $display("[TB] range boundary and infinity");
    applyStimulus(12, 1'b0);
    advanceTo(0);
    runGamma(12, 15, 1'b0);
    applyStimulus(13, 1'b0);
    advanceTo(0);
    runGamma(99, -1, 1'b1);
    applyStimulus(5, 1'b1);
    advanceTo(0);
    runGamma(99, -1, 1'b0);

    $display("[TB] back-to-back transfers");
    applyStimulus(2, 1'b0);
    t_valid = 1'b1;
    t_in    = GW'(5);
    t_inf   = 1'b0;
    checkOutput("b2b_ready_c1", int'(t_ready), 0);
    advanceTo(15);
    checkOutput("b2b_ready_c15", int'(t_ready), 0);
    tick();
    checkOutput("b2b_ready_c0", int'(t_ready), 1);
    checkOutput("b2b_y_c0", int'(y), 0);
    tick();
    t_valid = 1'b0;
    checkOutput("b2b_slot_full", int'(t_ready), 0);
    runGamma(2, 5, 1'b0);
    runGamma(5, 8, 1'b0);

    $display("[TB] bypass on wrap edge with t=0");
    advanceTo(15);
    t_valid = 1'b1;
    t_in    = '0;
    t_inf   = 1'b0;
    checkOutput("byp_ready_c15", int'(t_ready), 1);
    tick();
    t_valid = 1'b0;
    checkOutput("byp_ready_c0", int'(t_ready), 1);
    runGamma(0, 3, 1'b0);
    runGamma(99, -1, 1'b0);

    $display("[TB] reset in mid-pulse");
    applyStimulus(3, 1'b0);
    advanceTo(0);
    applyStimulus(6, 1'b0);
    advanceTo(4);
    checkOutput("pre_rst_y", int'(y), 1);
    grst = 1'b1;
    tick();
    checkOutput("mid_rst_y", int'(y), 0);
    tick();
    grst = 1'b0;
    checkOutput("post_rst_cnt", int'(gamma_cnt), 0);
    checkOutput("post_rst_start", int'(gamma_start), 1);
    checkOutput("post_rst_ready", int'(t_ready), 1);
    runGamma(99, -1, 1'b0);
    runGamma(99, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
